dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory target answering load/store requests from the MEM pipeline stage.
//  Word-organised RAM behind a req/ready handshake with a programmable wait-state count.
//  Models slow memory so that stage-stall logic can be exercised.
//  Flags misaligned or out-of-range accesses with an error response instead of
//  touching storage.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1
//  WAIT_CYCLES  2    cycles spent in WAIT before the response; 0 = response on the cycle after acceptance
//  AW           8    word-index width; must satisfy 2**AW >= DEPTH_WORDS
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  mem_req    in   1   request valid; initiator holds it and all request fields stable until mem_ready
//  mem_we     in   1   1 = store, 0 = load
//  mem_addr   in   32  byte address
//  mem_wdata  in   32  store data, lane-aligned (byte 0 = bits 7:0)
//  mem_be     in   4   store byte enables; ignored for loads
//  mem_rdata  out  32  load data; valid only while mem_ready=1 and mem_we=0
//  mem_ready  out  1   one-cycle response strobe; ends the transaction
//  mem_err    out  1   valid with mem_ready; 1 = access rejected
//  mem_busy   out  1   1 whenever state != IDLE; feeds the pipeline stall
// BEHAVIOUR
//  Reset (async): state=IDLE, counter=0; mem_ready=0, mem_err=0, mem_rdata=0, mem_busy=0.
//   RAM contents are NOT cleared by reset.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: if mem_req=1, capture we/addr/wdata/be.
//    Next state is WAIT with counter=WAIT_CYCLES-1 when WAIT_CYCLES>0, otherwise RESP.
//   WAIT: decrement counter each cycle; move to RESP on the cycle counter==0.
//   RESP: drive mem_ready=1 for exactly one cycle, then return to IDLE.
//  Latency: with request accepted at edge N, mem_ready is high in the cycle after edge N+1+WAIT_CYCLES.
//  Throughput: requests are sampled only in IDLE.
//   A req still high in the RESP cycle is NOT treated as a new request.
//   Back-to-back transactions therefore have one IDLE bubble.
//  Error check: mem_err=1 if addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS.
//   On error: no write occurs and rdata=0.
//   Check uses the captured address.
//  Store: bytes selected by be are written at the RESP edge. be=0000 is a legal no-op with err=0.
//  Load: rdata is registered from RAM[addr[AW+1:2]] so that it is valid throughout RESP.
//   Loads never modify RAM.
//  Read-after-write: a load issued after a store's RESP returns the new data; no bypass is needed.
//  rdata holds its last value outside RESP. Bench checks it only while ready=1.
//  Reset mid-transaction (WAIT or RESP): the transaction is aborted, no write occurs, no ready is emitted.
//  Request fields changing while in WAIT/RESP are ignored; the captured values are used.
// STRUCTURE
//  Shared package mips_mem_pkg:
//   - state encoding constants ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2
//   - MEM_BE_WORD=4'b1111
//   - address-alignment helper function
//  Sub-module dmem_ram: single-port word RAM with byte-write enables and registered read.
//   Instantiated once.
//  The FSM, counter, capture registers and error check live in dmem_responder.
// TESTING
//  1 Store 0xDEADBEEF @0x10 with be=1111, WAIT_CYCLES=2.
//    -> ready high exactly 4 cycles after acceptance edge, err=0.
//    Then load @0x10 -> rdata=0xDEADBEEF.
//  2 Store 0x000000AA @0x20 be=0001 over existing 0x11223344 -> load @0x20 returns 0x112233AA.
//  3 Load @0x13 (misaligned) -> ready=1, err=1, rdata=0. Load @0x400 with DEPTH 256 -> err=1.
//    RAM is unchanged in both cases.
//  4 WAIT_CYCLES=0, req held high for 3 back-to-back loads.
//    -> ready pulses 1-cycle wide every 3 cycles; busy drops for exactly one cycle between them.
//  5 Store 0x55 @0x8, assert rst during WAIT.
//    -> ready never pulses, outputs are 0 immediately, load @0x8 returns the old value.
//  6 Change mem_addr from 0x4 to 0x8 during WAIT -> response reflects 0x4.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared state encoding, byte-enable constant and alignment helper for the data memory
package mips_mem_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;
  localparam logic [3:0] MEM_BE_WORD = 4'b1111;
  function automatic logic addr_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word RAM with per-byte write enables and a registered read port
module dmem_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_q
);
  logic [31:0] r_mem [DEPTH_WORDS];
  // storage is never reset; only enabled byte lanes of a store are written
  always_ff @(posedge clk) begin
    if (i_en && i_we)
      for (int b = 0; b < 4; b++)
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
  end
  // read data is captured on every access and held between accesses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_q <= '0;
    else if (i_en) o_q <= r_mem[i_idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: req/ready data-memory target with programmable wait states and error responses
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_be,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        mem_busy
);
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_ready;
  logic        r_err;
  logic        w_err;
  logic        w_acc;
  logic [31:0] w_q;
  assign w_err = !addr_aligned(r_addr[1:0]) || ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_acc = (r_state == ST_RESP) && !r_ready && !w_err;
  assign mem_ready = r_ready;
  assign mem_err = r_err;
  assign mem_busy = r_state != ST_IDLE;
  assign mem_rdata = r_err ? '0 : w_q;
  // RESP spends one cycle performing the RAM access, then one cycle with ready raised
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_be <= '0;
      r_ready <= 1'b0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (mem_req) begin
          r_we <= mem_we;
          r_addr <= mem_addr;
          r_wdata <= mem_wdata;
          r_be <= mem_be & (mem_we ? MEM_BE_WORD : 4'b0000);
          r_cnt <= WAIT_CYCLES > 0 ? 8'(WAIT_CYCLES - 1) : 8'd0;
          r_state <= WAIT_CYCLES > 0 ? ST_WAIT : ST_RESP;
        end
        ST_WAIT: if (r_cnt == 8'd0) r_state <= ST_RESP;
          else r_cnt <= r_cnt - 8'd1;
        ST_RESP: if (!r_ready) begin
          r_ready <= 1'b1;
          r_err <= w_err;
        end else begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk(clk),
    .rst(rst),
    .i_en(w_acc),
    .i_we(r_we),
    .i_be(r_be),
    .i_idx(r_addr[AW+1:2]),
    .i_wdata(r_wdata),
    .o_q(w_q)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for two responders (2 wait states and 0 wait states)
module tb_dmem_responder;
  import mips_mem_pkg::*;
  typedef struct packed {logic ld; logic e; logic [31:0] d;} exp_t;
  logic clk, rst;
  logic req [2];
  logic we [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0] be [2];
  logic [31:0] rdata [2];
  logic ready [2];
  logic err [2];
  logic busy [2];
  logic [31:0] mdl [2][256];
  exp_t q0 [$];
  exp_t q1 [$];
  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(g == 0 ? 2 : 0), .AW(8)) u (
      .clk(clk), .rst(rst), .mem_req(req[g]), .mem_we(we[g]), .mem_addr(addr[g]),
      .mem_wdata(wdata[g]), .mem_be(be[g]), .mem_rdata(rdata[g]), .mem_ready(ready[g]),
      .mem_err(err[g]), .mem_busy(busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    exp_t ent;
    bit e;
    e = (a % 4 != 0) || (a / 4 >= 256);
    ent = '{ld: !w, e: e, d: 32'h0};
    if (!e && w) begin
      for (int i = 0; i < 4; i++) if (b[i]) mdl[k][a/4][8*i +: 8] = d[8*i +: 8];
    end
    if (!e && !w) ent.d = mdl[k][a/4];
    if (k == 0) q0.push_back(ent);
    else q1.push_back(ent);
  endtask

  task automatic xfer(input int k, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, input bit chg);
    int c;
    push_exp(k, w, a, d, b);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    c = 0;
    do begin @(negedge clk); c++; end while (!busy[k] && c < 50);
    if (!busy[k]) begin
      checks++; errors++;
      $display("FAIL accept_timeout: dut %0d addr %08h never went busy", k, a);
      req[k] = 1'b0;
      return;
    end
    if (chg) addr[k] = a ^ 32'h0000000C;
    c = 1;
    while (!ready[k] && c < 50) begin @(negedge clk); c++; end
    chk("latency", c, k == 0 ? 32'd4 : 32'd2);
    req[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ready[k]) begin
        exp_t e;
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: dut %0d pulsed ready with nothing outstanding", k);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk("err", {31'b0, err[k]}, {31'b0, e.e});
          if (e.ld) chk("rdata", rdata[k], e.d);
        end
      end
    end
  end

  initial begin
    int p [3];
    int np, lowc;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; be[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", {31'b0, ready[k]}, 32'd0);
      chk("rst_err", {31'b0, err[k]}, 32'd0);
      chk("rst_rdata", rdata[k], 32'd0);
      chk("rst_busy", {31'b0, busy[k]}, 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) xfer(k, 1'b1, i * 4, $urandom, MEM_BE_WORD, 1'b0);
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0);
    xfer(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 1'b0);
    xfer(0, 1'b1, 32'h20, 32'h000000AA, 4'b0001, 1'b0);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'b0000, 1'b0);
    xfer(0, 1'b0, 32'h13, 32'h0, 4'b0000, 1'b0);
    xfer(0, 1'b0, 32'h400, 32'h0, 4'b0000, 1'b0);
    xfer(0, 1'b1, 32'h12, 32'hCAFEF00D, 4'b1111, 1'b0);
    xfer(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'b1111, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0);
    xfer(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'b0000, 1'b0);
    // reset during WAIT aborts the store to 0x8
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'h55; be[0] = 4'b1111;
    @(negedge clk);
    chk("busy_in_wait", {31'b0, busy[0]}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_ready", {31'b0, ready[0]}, 32'd0);
    chk("abort_err", {31'b0, err[0]}, 32'd0);
    chk("abort_rdata", rdata[0], 32'd0);
    chk("abort_busy", {31'b0, busy[0]}, 32'd0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xfer(0, 1'b0, 32'h8, 32'h0, 4'b0000, 1'b0);
    // captured address is used even if mem_addr moves during WAIT
    xfer(0, 1'b1, 32'h4, 32'h44444444, 4'b1111, 1'b0);
    xfer(0, 1'b1, 32'h8, 32'h88888888, 4'b1111, 1'b0);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'b0000, 1'b1);
    // zero-wait responder with req held high across three loads
    for (int i = 0; i < 3; i++) push_exp(1, 1'b0, 32'h40, 32'h0, 4'b0000);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40; be[1] = 4'b0000;
    np = 0; lowc = 0;
    for (int t = 0; t < 40 && np < 3; t++) begin
      @(negedge clk);
      if (np > 0 && !busy[1]) lowc++;
      if (ready[1]) begin p[np] = t; np++; end
    end
    req[1] = 1'b0;
    chk("hold_pulses", np, 32'd3);
    chk("hold_period1", p[1] - p[0], 32'd3);
    chk("hold_period2", p[2] - p[1], 32'd3);
    chk("hold_idle_gaps", lowc, 32'd2);
    repeat (3) @(negedge clk);
    chk("hold_no_extra", {31'b0, busy[1]}, 32'd0);
    for (int i = 0; i < 300; i++) begin
      int k;
      logic [31:0] a;
      k = (i % 3 == 2) ? 1 : 0;
      a = $urandom_range(0, 299) * 4 + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
      xfer(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end
    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
